// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle phase sequencer for the 8-bit ExceptioNull CPU
module cpu_sequencer #(
    parameter logic [3:0] HALT_OPCODE = 4'b1111,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic [3:0]  opcode,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        mem_ready,
    output logic        fetch,
    output logic        decode,
    output logic        reg_read,
    output logic        execute,
    output logic        access_mem,
    output logic        wb_resolve,
    output logic        reg_write,
    output logic        update_pc,
    output logic [3:0]  state,
    output logic        busy,
    output logic        halted,
    output logic        mem_timeout_err,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REGRD  = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_WBRES  = 4'd6,
        S_WB     = 4'd7,
        S_PCUPD  = 4'd8,
        S_HALT   = 4'd9,
        S_ERROR  = 4'd10
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] instr_count_q, instr_count_d;

    // State, memory wait counter and retired-instruction counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic: phase walk, memory wait with timeout, halt/run decision at PC update
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        instr_count_d = instr_count_q;
        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_REGRD;
            S_REGRD:  state_d = S_EXEC;
            S_EXEC: begin
                if (mem_r_en || mem_w_en) begin
                    state_d    = S_MEM;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = S_WBRES;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WBRES;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TIMEOUT_CNT) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_WBRES: state_d = S_WB;
            S_WB:    state_d = S_PCUPD;
            S_PCUPD: begin
                instr_count_d = instr_count_q + 16'd1;
                if (opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobes; access_mem only on the first MEM cycle (wait counter still zero)
    always_comb begin
        fetch           = 1'b0;
        decode          = 1'b0;
        reg_read        = 1'b0;
        execute         = 1'b0;
        access_mem      = 1'b0;
        wb_resolve      = 1'b0;
        reg_write       = 1'b0;
        update_pc       = 1'b0;
        halted          = 1'b0;
        mem_timeout_err = 1'b0;
        busy            = 1'b1;
        case (state_q)
            S_FETCH:  fetch      = 1'b1;
            S_DECODE: decode     = 1'b1;
            S_REGRD:  reg_read   = 1'b1;
            S_EXEC:   execute    = 1'b1;
            S_MEM:    access_mem = (wait_cnt_q == 8'd0);
            S_WBRES:  wb_resolve = 1'b1;
            S_WB:     reg_write  = 1'b1;
            S_PCUPD:  update_pc  = 1'b1;
            S_IDLE:   busy       = 1'b0;
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_ERROR: begin
                busy            = 1'b0;
                mem_timeout_err = 1'b1;
            end
            default:  busy = 1'b0;
        endcase
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, step, mem_r_en, mem_w_en, mem_ready;
    logic [3:0]  opcode;
    logic        fetch, decode, reg_read, execute, access_mem, wb_resolve, reg_write, update_pc;
    logic [3:0]  state;
    logic        busy, halted, mem_timeout_err;
    logic [15:0] instr_count;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_REGRD = 4'd3,
                           S_EXEC = 4'd4, S_MEM = 4'd5, S_WBRES = 4'd6, S_WB = 4'd7,
                           S_PCUPD = 4'd8, S_HALT = 4'd9, S_ERROR = 4'd10;

    localparam logic [7:0] SB_FETCH = 8'h80, SB_DECODE = 8'h40, SB_REGRD = 8'h20, SB_EXEC = 8'h10,
                           SB_MEM = 8'h08, SB_WBRES = 8'h04, SB_WB = 8'h02, SB_PCUPD = 8'h01;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_ready(mem_ready),
        .fetch(fetch), .decode(decode), .reg_read(reg_read), .execute(execute),
        .access_mem(access_mem), .wb_resolve(wb_resolve), .reg_write(reg_write),
        .update_pc(update_pc), .state(state), .busy(busy), .halted(halted),
        .mem_timeout_err(mem_timeout_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [7:0]  sv;
        logic [15:0] cnt;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    logic [15:0] exp_count = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with a strobe high must match the next expected phase
    always @(negedge clk) begin
        logic [7:0] sv;
        exp_t       e;
        int         gap;
        sv = {fetch, decode, reg_read, execute, access_mem, wb_resolve, reg_write, update_pc};
        if (sv != 8'd0) begin
            gap      = cyc - last_cyc;
            last_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: state=%0d strobes=%b (none expected)", state, sv);
            end else begin
                e = exp_q.pop_front();
                if (state !== e.st || sv !== e.sv || instr_count !== e.cnt || (e.gap != 0 && gap != e.gap)) begin
                    bad++;
                    $display("FAIL strobe_seq: got state=%0d strobes=%b cnt=%h gap=%0d, want state=%0d strobes=%b cnt=%h gap=%0d",
                             state, sv, instr_count, gap, e.st, e.sv, e.cnt, e.gap);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [7:0] sv, input int gap);
        exp_t e;
        e.st  = st;
        e.sv  = sv;
        e.cnt = exp_count;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_front_half(input int first_gap);
        push(S_FETCH, SB_FETCH, first_gap);
        push(S_DECODE, SB_DECODE, 1);
        push(S_REGRD, SB_REGRD, 1);
        push(S_EXEC, SB_EXEC, 1);
    endtask

    task automatic push_instr(input int first_gap, input bit mem, input int mem_cycles);
        push_front_half(first_gap);
        if (mem) begin
            push(S_MEM, SB_MEM, 1);
            push(S_WBRES, SB_WBRES, mem_cycles);
        end else begin
            push(S_WBRES, SB_WBRES, 1);
        end
        push(S_WB, SB_WB, 1);
        push(S_PCUPD, SB_PCUPD, 1);
        exp_count = exp_count + 16'd1;
    endtask

    task automatic wait_state(input logic [3:0] target, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (state == target) break;
            tick();
        end
        check(name, 32'(state), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 16'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'd0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_ready = 1'b0;
        do_reset();
        check("reset_outputs",
              32'({state, fetch, decode, reg_read, execute, access_mem, wb_resolve, reg_write,
                   update_pc, busy, halted, mem_timeout_err, instr_count}), 32'd0);

        // back-to-back non-memory instructions under run
        push_instr(0, 0, 0);
        push_instr(1, 0, 0);
        push_instr(1, 0, 0);
        run = 1'b1;
        repeat (20) tick();
        run = 1'b0;
        wait_state(S_IDLE, 20, "run3_idle");
        check("run3_count", 32'(instr_count), 32'd3);
        check("run3_busy", 32'(busy), 32'd0);

        // single step; a second step during DECODE is dropped
        do_reset();
        push_instr(0, 0, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("step_in_decode", 32'(state), 32'(S_DECODE));
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_state(S_IDLE, 20, "step_idle");
        check("step_count", 32'(instr_count), 32'd1);
        check("step_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        check("step_stays_idle", 32'(state), 32'(S_IDLE));

        // memory read, ready on the third MEM cycle
        mem_r_en = 1'b1;
        push_instr(0, 1, 3);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (6) tick();
        check("mem_third_cycle", 32'(state), 32'(S_MEM));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("mem_to_wbres", 32'(state), 32'(S_WBRES));
        wait_state(S_IDLE, 20, "mem_idle");
        mem_r_en = 1'b0;
        check("mem_count", 32'(instr_count), 32'd2);

        // memory write that never completes -> ERROR after 15 MEM cycles
        mem_w_en = 1'b1;
        push_front_half(0);
        push(S_MEM, SB_MEM, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (18) tick();
        check("timeout_mem15", 32'({state, mem_timeout_err}), 32'({S_MEM, 1'b0}));
        tick();
        check("timeout_error", 32'({state, mem_timeout_err, busy, halted}), 32'({S_ERROR, 3'b100}));
        run = 1'b1;
        step = 1'b1;
        repeat (5) tick();
        check("error_sticky", 32'(state), 32'(S_ERROR));
        check("error_count", 32'(instr_count), 32'd2);
        run = 1'b0;
        step = 1'b0;
        mem_w_en = 1'b0;
        do_reset();
        check("error_cleared", 32'({state, mem_timeout_err}), 32'({S_IDLE, 1'b0}));

        // HALT opcode under run
        opcode = 4'b1111;
        push_instr(0, 0, 0);
        run = 1'b1;
        wait_state(S_HALT, 20, "halt_state");
        check("halt_flags", 32'({halted, busy, instr_count}), 32'({2'b10, 16'd1}));
        repeat (8) tick();
        check("halt_sticky", 32'(state), 32'(S_HALT));
        run = 1'b0;
        opcode = 4'd0;

        // reset in EXEC aborts the instruction
        do_reset();
        push_front_half(0);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        check("abort_in_exec", 32'(state), 32'(S_EXEC));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_idle",
              32'({state, fetch, decode, reg_read, execute, access_mem, wb_resolve, reg_write, update_pc}), 32'd0);
        repeat (3) tick();
        check("abort_stays_idle", 32'(state), 32'(S_IDLE));

        // instruction counter wrap
        force dut.instr_count_q = 16'hFFFF;
        #2;
        release dut.instr_count_q;
        exp_count = 16'hFFFF;
        check("wrap_preload", 32'(instr_count), 32'h0000FFFF);
        push_instr(0, 0, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_state(S_IDLE, 20, "wrap_idle");
        check("wrap_count", 32'(instr_count), 32'd0);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
